// File: rtl/caravel_sram_scan_pkg.sv
// Shared definitions for the scan-chain SRAM test block: scan field positions,
// bank select codes and word geometry.
package caravel_sram_scan_pkg;

  localparam int SCAN_W = 112;
  localparam int WORD_W = 32;
  localparam int BYTES  = WORD_W / 8;

  localparam int SEL_MSB    = 111;
  localparam int SEL_LSB    = 108;
  localparam int ADDR0_LSB  = 92;
  localparam int DIN0_MSB   = 91;
  localparam int DIN0_LSB   = 60;
  localparam int CSB0_BIT   = 59;
  localparam int WEB0_BIT   = 58;
  localparam int WMASK0_MSB = 57;
  localparam int WMASK0_LSB = 54;
  localparam int ADDR1_LSB  = 38;
  localparam int DIN1_MSB   = 37;
  localparam int DIN1_LSB   = 6;
  localparam int CSB1_BIT   = 5;
  localparam int WEB1_BIT   = 4;
  localparam int WMASK1_MSB = 3;
  localparam int WMASK1_LSB = 0;

  localparam int NUM_DP_BANKS = 5;
  localparam int NUM_SP_BANKS = 5;
  localparam int NUM_BANKS    = NUM_DP_BANKS + NUM_SP_BANKS;

  localparam logic [3:0] DP_SEL_FIRST = 4'd0;
  localparam logic [3:0] SP_SEL_FIRST = 4'd8;

  // Bank indices 0..4 map to dual-port codes 0..4, indices 5..9 to single-port codes 8..12.
  function automatic logic [3:0] bankSel(input int idx);
    if (idx < NUM_DP_BANKS) return 4'(int'(DP_SEL_FIRST) + idx);
    return 4'(int'(SP_SEL_FIRST) + idx - NUM_DP_BANKS);
  endfunction

endpackage

// File: rtl/caravel_sram_scan_bank.sv
// One SRAM bank: NUM_WORDS x 32 with byte-masked synchronous write and
// registered read; port 1 exists only when DUAL_PORT is set.
module sram_bank
  import caravel_sram_scan_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter bit DUAL_PORT = 1'b1
) (
  input  logic                         clock,
  input  logic                         resetb,
  input  logic                         en_i,
  input  logic                         csb0_i,
  input  logic                         web0_i,
  input  logic [BYTES-1:0]             wmask0_i,
  input  logic [$clog2(NUM_WORDS)-1:0] addr0_i,
  input  logic [WORD_W-1:0]            din0_i,
  input  logic                         csb1_i,
  input  logic                         web1_i,
  input  logic [BYTES-1:0]             wmask1_i,
  input  logic [$clog2(NUM_WORDS)-1:0] addr1_i,
  input  logic [WORD_W-1:0]            din1_i,
  output logic [WORD_W-1:0]            rdata0_o,
  output logic [WORD_W-1:0]            rdata1_o
);

  logic [WORD_W-1:0] mem [NUM_WORDS];
  logic [WORD_W-1:0] rdata0_q, rdata1_q;
  logic              port0On, port1On;

  assign port0On = en_i & ~csb0_i;
  assign port1On = en_i & ~csb1_i & DUAL_PORT;

  // Contents survive reset; port 0 is written last so it wins a same-byte collision.
  always_ff @(posedge clock) begin
    for (int k = 0; k < BYTES; k++) begin
      if (port1On && !web1_i && wmask1_i[k]) mem[addr1_i][8*k +: 8] <= din1_i[8*k +: 8];
      if (port0On && !web0_i && wmask0_i[k]) mem[addr0_i][8*k +: 8] <= din0_i[8*k +: 8];
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (en_i) begin
      rdata0_q <= (port0On && web0_i) ? mem[addr0_i] : '0;
      rdata1_q <= (port1On && web1_i) ? mem[addr1_i] : '0;
    end
  end

  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: rtl/caravel_sram_scan.sv
// Scan-chain driven SRAM test block: a 112-bit shift register carries the bank
// command, an access strobe executes it and a load pulse captures the read data.
module caravel_sram_scan
  import caravel_sram_scan_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int SCAN_W    = caravel_sram_scan_pkg::SCAN_W
) (
  input  logic clock,
  input  logic resetb,
  input  logic scan_en,
  input  logic scan_in,
  input  logic sram_load,
  input  logic global_csb,
  output logic scan_out
);

  localparam int AW = $clog2(NUM_WORDS);

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [WORD_W-1:0] dout0_q, dout1_q;
  logic [WORD_W-1:0] rd0Mux, rd1Mux;
  logic [3:0]        selAcc_q;
  logic [3:0]        sel;
  logic              access;
  logic [WORD_W-1:0] bankRd0 [NUM_BANKS];
  logic [WORD_W-1:0] bankRd1 [NUM_BANKS];

  assign sel = scan_q[SEL_MSB:SEL_LSB];
  // Gating with resetb keeps the all-zero reset pattern from writing bank 0.
  assign access = ~global_csb & resetb;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
    sram_bank #(
      .NUM_WORDS(NUM_WORDS),
      .DUAL_PORT(b < NUM_DP_BANKS)
    ) uBank (
      .clock   (clock),
      .resetb  (resetb),
      .en_i    (access && (sel == bankSel(b))),
      .csb0_i  (scan_q[CSB0_BIT]),
      .web0_i  (scan_q[WEB0_BIT]),
      .wmask0_i(scan_q[WMASK0_MSB:WMASK0_LSB]),
      .addr0_i (scan_q[ADDR0_LSB +: AW]),
      .din0_i  (scan_q[DIN0_MSB:DIN0_LSB]),
      .csb1_i  (scan_q[CSB1_BIT]),
      .web1_i  (scan_q[WEB1_BIT]),
      .wmask1_i(scan_q[WMASK1_MSB:WMASK1_LSB]),
      .addr1_i (scan_q[ADDR1_LSB +: AW]),
      .din1_i  (scan_q[DIN1_MSB:DIN1_LSB]),
      .rdata0_o(bankRd0[b]),
      .rdata1_o(bankRd1[b])
    );
  end

  // Read data follows the bank chosen at the last access; unused codes read 0.
  always_comb begin
    rd0Mux = '0;
    rd1Mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (selAcc_q == bankSel(b)) begin
        rd0Mux = bankRd0[b];
        rd1Mux = bankRd1[b];
      end
    end
  end

  always_comb begin
    scan_d = scan_q;
    if (sram_load) begin
      scan_d[DIN0_MSB:DIN0_LSB] = dout0_q;
      scan_d[DIN1_MSB:DIN1_LSB] = dout1_q;
    end else if (scan_en) begin
      scan_d = {scan_q[SCAN_W-2:0], scan_in};
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      scan_q   <= '0;
      dout0_q  <= '0;
      dout1_q  <= '0;
      selAcc_q <= '0;
    end else begin
      scan_q  <= scan_d;
      dout0_q <= rd0Mux;
      dout1_q <= rd1Mux;
      if (access) selAcc_q <= sel;
    end
  end

  assign scan_out = scan_q[SEL_MSB];

endmodule

// File: tb/tb_caravel_sram_scan.sv
// Scoreboard bench: each transaction pushes the expected unloaded scan word,
// and a monitor reassembles scan_out bits and compares against the queue.
module tb_caravel_sram_scan;

  localparam int NW = 16;

  logic clock = 1'b0;
  logic resetb, scan_en, scan_in, sram_load, global_csb;
  logic scan_out;

  int checks = 0;
  int failures = 0;

  logic [111:0] expQ [$];
  bit           collecting = 1'b0;
  bit           pending = 1'b0;
  logic [31:0]  model [10][NW];
  bit           known [10][NW];

  logic [111:0] got;
  logic [111:0] expWord;
  int           nBits = 0;

  always #5 clock = ~clock;

  caravel_sram_scan #(.NUM_WORDS(NW)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .sram_load (sram_load),
    .global_csb(global_csb),
    .scan_out  (scan_out)
  );

  // Monitor: gathers 112 serial bits MSB first, then checks against the scoreboard.
  always @(negedge clock) begin
    if (collecting) begin
      got = {got[110:0], scan_out};
      nBits++;
      if (nBits == 112) begin
        nBits = 0;
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL scan_word got=%h want=<none queued>", got);
        end else begin
          expWord = expQ.pop_front();
          if (got !== expWord) begin
            failures++;
            $display("[TB] FAIL scan_word got=%h want=%h", got, expWord);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic int bankIdx(input logic [3:0] s);
    if (s <= 4'd4) return int'(s);
    if (s >= 4'd8 && s <= 4'd12) return int'(s) - 3;
    return -1;
  endfunction

  function automatic logic [111:0] mkWord(
    input logic [3:0] sel,
    input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
    input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1, input logic [3:0] m1);
    return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
  endfunction

  // Reference behaviour of one access: reads see old contents, port 0 overrides port 1.
  function automatic void modelAccess(input logic [111:0] w, output logic [31:0] r0,
                                      output logic [31:0] r1);
    int b, a0, a1;
    bit en0, en1;
    r0 = '0;
    r1 = '0;
    b = bankIdx(w[111:108]);
    if (b < 0) return;
    a0 = int'(w[107:92]) % NW;
    a1 = int'(w[53:38]) % NW;
    en0 = !w[59];
    en1 = !w[5] && (b < 5);
    if (en0 && w[58]) r0 = model[b][a0];
    if (en1 && w[4]) r1 = model[b][a1];
    if (en1 && !w[4]) begin
      for (int k = 0; k < 4; k++) if (w[k]) model[b][a1][8*k +: 8] = w[6 + 8*k +: 8];
      known[b][a1] = 1'b1;
    end
    if (en0 && !w[58]) begin
      for (int k = 0; k < 4; k++) if (w[54 + k]) model[b][a0][8*k +: 8] = w[60 + 8*k +: 8];
      known[b][a0] = 1'b1;
    end
  endfunction

  // Random commands never touch never-written words except with a full-mask write.
  function automatic logic [111:0] fixup(input logic [111:0] wIn);
    logic [111:0] w;
    int b;
    w = wIn;
    b = bankIdx(w[111:108]);
    if (b < 0) return w;
    if (!w[5] && b < 5 && !known[b][int'(w[53:38]) % NW]) begin
      w[4] = 1'b0;
      w[3:0] = 4'hF;
    end
    if (!w[59] && !known[b][int'(w[107:92]) % NW]) begin
      w[58] = 1'b0;
      w[57:54] = 4'hF;
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic scanWord(input logic [111:0] w, input bit collect);
    @(posedge clock); #1;
    collecting = collect;
    scan_en = 1'b1;
    for (int i = 111; i >= 0; i--) begin
      scan_in = w[i];
      @(posedge clock); #1;
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
    collecting = 1'b0;
  endtask

  task automatic applyStimulus(input logic [111:0] w, input bit shiftAcc, input bit shiftBit);
    logic [31:0]  r0, r1;
    logic [111:0] e;
    bit           c;
    c = pending;
    pending = 1'b0;
    scanWord(w, c);
    global_csb = 1'b0;
    scan_en = shiftAcc;
    scan_in = shiftBit;
    @(posedge clock); #1;
    global_csb = 1'b1;
    scan_en = 1'b0;
    scan_in = 1'b0;
    modelAccess(w, r0, r1);
    @(posedge clock); #1;
    sram_load = 1'b1;
    @(posedge clock); #1;
    sram_load = 1'b0;
    e = shiftAcc ? {w[110:0], shiftBit} : w;
    e[91:60] = r0;
    e[37:6] = r1;
    expQ.push_back(e);
    pending = 1'b1;
  endtask

  task automatic resetMidScan();
    scanWord({112{1'b1}}, pending);
    pending = 1'b0;
    scan_en = 1'b1;
    scan_in = 1'b1;
    repeat (50) begin @(posedge clock); #1; end
    scan_en = 1'b0;
    checkOutput("pre_reset_scan_out", 32'(scan_out), 32'd1);
    resetb = 1'b0;
    global_csb = 1'b0;
    #1;
    checkOutput("reset_scan_out", 32'(scan_out), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    global_csb = 1'b1;
    resetb = 1'b1;
    expQ.push_back('0);
    pending = 1'b1;
  endtask

  initial begin
    logic [111:0] w;
    logic [127:0] t;
    logic [111:0] pat;

    resetb = 1'b1;
    scan_en = 1'b0;
    scan_in = 1'b0;
    sram_load = 1'b0;
    global_csb = 1'b1;
    #2 resetb = 1'b0;
    #1 checkOutput("reset_initial_scan_out", 32'(scan_out), 32'd0);
    repeat (2) @(posedge clock);
    #1 resetb = 1'b1;
    expQ.push_back('0);
    pending = 1'b1;

    // Shift/echo with no access.
    pat = 112'h0123_4567_89AB_CDEF_FEDC_BA98_7654;
    scanWord(pat, pending);
    pending = 1'b0;
    expQ.push_back(pat);
    pending = 1'b1;

    // Dual-port banks: two writes then a read on both ports.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mkWord(4'(i), 16'd1, 32'(i), 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);
      applyStimulus(mkWord(4'(i), 16'd2, 32'(i) << 3, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);
      applyStimulus(mkWord(4'(i), 16'd1, 32'd0, 0, 1, 4'hF, 16'd2, 32'd0, 0, 1, 4'hF), 0, 0);
    end
    applyStimulus(mkWord(4'd0, 16'd0, 32'hA5A5_5A5A, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);

    // Single-port banks; port 1 is absent so it always reads 0.
    for (int s = 8; s <= 12; s++) begin
      applyStimulus(mkWord(4'(s), 16'd1, 32'hDEAD_BEEF, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);
      applyStimulus(mkWord(4'(s), 16'd1, 32'd0, 0, 1, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);
    end
    applyStimulus(mkWord(4'd8, 16'd1, 32'd0, 0, 1, 4'hF, 16'd1, 32'd0, 0, 1, 4'hF), 0, 0);

    // Byte mask.
    applyStimulus(mkWord(4'd3, 16'd5, 32'hFFFF_FFFF, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);
    applyStimulus(mkWord(4'd3, 16'd5, 32'h0000_0000, 0, 0, 4'b0101, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);
    applyStimulus(mkWord(4'd3, 16'd5, 32'd0, 0, 1, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);

    // Same-word conflicts.
    applyStimulus(mkWord(4'd1, 16'd7, 32'hCAFE_F00D, 0, 0, 4'hF, 16'd0, 32'd0, 1, 1, 4'h0), 0, 0);
    applyStimulus(mkWord(4'd1, 16'd7, 32'h1111_1111, 0, 0, 4'hF, 16'd7, 32'd0, 0, 1, 4'hF), 0, 0);
    applyStimulus(mkWord(4'd1, 16'd7, 32'h3333_3333, 0, 0, 4'b0011, 16'd7, 32'h4444_4444, 0, 0, 4'hF), 0, 0);
    applyStimulus(mkWord(4'd1, 16'd7, 32'd0, 0, 1, 4'hF, 16'd7, 32'd0, 0, 1, 4'hF), 0, 0);

    // Invalid select, then every bank re-read (upper address bits ignored).
    applyStimulus(mkWord(4'd6, 16'd1, 32'h1234_5678, 0, 0, 4'hF, 16'd1, 32'h8765_4321, 0, 0, 4'hF), 0, 0);
    applyStimulus(mkWord(4'd6, 16'd1, 32'd0, 0, 1, 4'hF, 16'd1, 32'd0, 0, 1, 4'hF), 0, 0);
    for (int b = 0; b < 10; b++) begin
      int s;
      s = (b < 5) ? b : b + 3;
      applyStimulus(mkWord(4'(s), 16'hFFF1, 32'd0, 0, 1, 4'hF, 16'h0001, 32'd0, 1, 1, 4'h0), 0, 0);
    end

    // Access while shifting uses the pre-edge command.
    applyStimulus(mkWord(4'd2, 16'd1, 32'd0, 0, 1, 4'hF, 16'd2, 32'd0, 0, 1, 4'hF), 1, 1);

    // Reset mid-scan keeps SRAM contents.
    resetMidScan();
    applyStimulus(mkWord(4'd2, 16'd1, 32'd0, 0, 1, 4'hF, 16'd2, 32'd0, 0, 1, 4'hF), 0, 0);
    applyStimulus(mkWord(4'd0, 16'd0, 32'd0, 0, 1, 4'hF, 16'd1, 32'd0, 0, 1, 4'hF), 0, 0);

    // Randomized commands checked against the reference model.
    for (int n = 0; n < 40; n++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      w = t[111:0];
      w[107:92] = w[107:92] & 16'hFFF3;
      w[53:38] = w[53:38] & 16'hFFF3;
      w[59] = ($urandom_range(0, 3) == 0);
      w[5] = ($urandom_range(0, 2) == 0);
      applyStimulus(fixup(w), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    scanWord('0, pending);
    pending = 1'b0;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/caravel_sram_scan.md
CARAVEL_SRAM_SCAN -- requirements
Module: caravel_sram_scan

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16, meaning words per SRAM bank (power of two, at least 2).
REQ-002 SHALL have parameter SCAN_W, default 112, meaning scan register width (fixed field map, REQ-010).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetb, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port scan_en, input, 1 bit: shift enable for the scan register.
REQ-006 SHALL have port scan_in, input, 1 bit: serial data in.
REQ-007 SHALL have port sram_load, input, 1 bit: copy captured read data into the scan register.
REQ-008 SHALL have port global_csb, input, 1 bit: active-low SRAM access strobe.
REQ-009 SHALL have port scan_out, output, 1 bit: serial data out, always equal to scan register bit 111.

Function
REQ-010 Scan register field map, MSB to LSB:
- sel[111:108]
- addr0[107:92], din0[91:60], csb0[59], web0[58], wmask0[57:54]
- addr1[53:38], din1[37:6], csb1[5], web1[4], wmask1[3:0]
REQ-011 Shift: with scan_en=1 and sram_load=0, each edge shifts the register left by one; scan_in enters bit 0. A 112-bit word presented MSB first is therefore fully loaded after 112 edges.
REQ-012 Load: sram_load=1 has priority over scan_en. On that edge, din0 takes dout0_q and din1 takes dout1_q; all other bits hold.
REQ-013 Hold: with scan_en=0 and sram_load=0, the register holds.
REQ-014 Banks: sel 0-4 are dual-port banks (ports 0 and 1); sel 8-12 are single-port banks (port 0 only).
REQ-015 sel values 5-7 and 13-15 select no bank: no write occurs and read data is 0.
REQ-016 Bank geometry: each bank is NUM_WORDS x 32 bits, addressed by the low log2(NUM_WORDS) bits of addr; upper address bits are ignored.
REQ-017 Access edge E is any edge with global_csb=0. At E each enabled port (csbN=0) of the selected bank acts on the register contents as they stood before E:
- write if webN=0: byte k written only when wmaskN[k]=1;
- read if webN=1: the addressed word goes to that port's read register.
REQ-018 Disabled or absent port: a port with csbN=1, or port 1 of a single-port bank, yields read value 0.
REQ-019 dout0_q and dout1_q capture the port read registers at edge E+1. sram_load is legal from E+2 onward.
REQ-020 Back-to-back access (global_csb held low on several edges): one access per edge.
REQ-021 Port conflicts on the same word in one access:
- port0 write with port1 read: port1 returns the old data;
- both ports writing: port0 wins.
REQ-022 Access while shifting: scan_en=1 together with global_csb=0 is legal; the access uses the pre-edge contents.
REQ-023 SRAM contents are undefined until written; the block performs no initialisation.

Reset
REQ-024 resetb=0 SHALL immediately clear the scan register, both port read registers and dout0_q/dout1_q to 0; scan_out therefore reads 0.
REQ-025 Reset SHALL NOT alter SRAM contents. Assertion mid-shift or mid-access aborts the operation, and any write not yet committed at an edge is lost.

Structure
REQ-026 A shared package caravel_sram_scan_pkg SHALL hold the field bit-position constants, the bank sel codes (DP 0-4, SP 8-12) and SCAN_W.
REQ-027 One sub-module sram_bank SHALL model a single bank, with parameter DUAL_PORT and byte-masked synchronous write/read. The top level instantiates 5 dual-port and 5 single-port copies plus a select/read mux.

Verification
REQ-028 Shift/echo: shift in 112'h0123...CDEF (any pattern) with no access, then shift 112 more edges. scan_out SHALL reproduce the pattern MSB first.
REQ-029 Dual-port write/read, for sel=i, i=0..4:
- write din0=i to addr 1 (wmask F);
- write din0=i<<3 to addr 2;
- read with port0 at addr 1 and port1 at addr 2;
- after load, scan-out SHALL equal the input word with din0=i and din1=i<<3.
REQ-030 Single-port, for sel=8..12: write 32'hDEADBEEF to addr 1, then read with csb1=1. Scan-out SHALL show din0=DEADBEEF and din1=0.
REQ-031 Byte mask: write FFFFFFFF, then write 00000000 with wmask0=4'b0101, then read. Result SHALL be FF00FF00.
REQ-032 Invalid sel=6: write to addr 1, then read. Read data SHALL be 0, and banks 0-4 and 8-12 SHALL keep their prior values.
REQ-033 Reset mid-scan: assert resetb=0 after 50 shift edges. scan_out=0 immediately, and a subsequent read of a previously written word SHALL return its original value.
